// File: rtl/mem_axi_pkg.sv
// Shared AXI read-side definitions for the memory responder: burst and response codes,
// line geometry and the responder FSM state type.
package mem_axi_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int BEATS_PER_LINE = 8;
   localparam int LINE_BYTES     = 64;
   localparam int BEAT_W         = 64;
   localparam int LINE_W         = BEATS_PER_LINE * BEAT_W;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND
   } rd_state_e;

   // Only full-line 64-bit WRAP bursts map onto the line buffer.
   function automatic logic is_legal_req(input logic [3:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
      return (len == 4'd7) && (size == 3'd3) && (burst == BURST_WRAP);
   endfunction

endpackage

// File: rtl/mem_ar_fifo.sv
// Small synchronous FIFO for queued AR requests; full/empty come straight from flops
// so the AR ready path has no combinational dependence on the pop side.
module mem_ar_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push = push_i && !full_q;
      do_pop  = pop_i && !empty_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) begin
         wptr_d = wptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rptr_d = rptr_q + PTR_ONE;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!do_push && do_pop) begin
         count_d = count_q - CNT_ONE;
      end
      full_d  = (count_d == CNT_FULL);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/mem_rd_burst_responder.sv
// AXI R-channel responder: queues AR requests, reads one 64-byte line per request and
// returns it as 8 WRAP-ordered beats from the critical word; unsupported shapes get SLVERR.
module mem_rd_burst_responder
   import mem_axi_pkg::*;
#(
   parameter int AR_FIFO_DEPTH = 4,
   parameter int ID_W          = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              arvalid_i,
   output logic              arready_o,
   input  logic [31:0]       araddr_i,
   input  logic [ID_W-1:0]   arid_i,
   input  logic [3:0]        arlen_i,
   input  logic [2:0]        arsize_i,
   input  logic [1:0]        arburst_i,
   output logic              rvalid_o,
   input  logic              rready_i,
   output logic [63:0]       rdata_o,
   output logic [1:0]        rresp_o,
   output logic [ID_W-1:0]   rid_o,
   output logic              rlast_o,
   output logic              line_rden_o,
   output logic [25:0]       line_raddr_o,
   input  logic [LINE_W-1:0] line_rdata_i
);

   // Queue entry: {addr[31:3], id, len, legal}; byte-lane bits never affect a 64-bit beat.
   localparam int ENTRY_W = 29 + ID_W + 4 + 1;

   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] head_entry;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;
   logic [28:0]        head_addr;
   logic [ID_W-1:0]    head_id;
   logic [3:0]         head_len;
   logic               head_legal;
   logic               unused_addr_lsb;

   rd_state_e          state_q, state_d;
   logic [2:0]         off_q, off_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [3:0]         len_q, len_d;
   logic               err_q, err_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [LINE_W-1:0]  line_q, line_d;
   logic [2:0]         beat_idx;
   logic               is_last;
   logic [BEAT_W-1:0]  line_words [BEATS_PER_LINE];

   assign unused_addr_lsb = ^araddr_i[2:0];
   assign push_entry = {araddr_i[31:3], arid_i, arlen_i,
                        is_legal_req(arlen_i, arsize_i, arburst_i)};

   mem_ar_fifo #(
      .DEPTH (AR_FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_ar_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (arvalid_i),
      .wdata_i (push_entry),
      .pop_i   (fifo_pop),
      .rdata_o (head_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign arready_o  = !fifo_full;
   assign head_addr  = head_entry[ENTRY_W-1 -: 29];
   assign head_id    = head_entry[ID_W+4:5];
   assign head_len   = head_entry[4:1];
   assign head_legal = head_entry[0];

   for (genvar gi = 0; gi < BEATS_PER_LINE; gi++) begin : g_words
      assign line_words[gi] = line_q[gi*BEAT_W +: BEAT_W];
   end

   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      id_d         = id_q;
      len_d        = len_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      line_d       = line_q;
      fifo_pop     = 1'b0;
      line_rden_o  = 1'b0;
      line_raddr_o = head_addr[28:3];
      rvalid_o     = 1'b0;
      rdata_o      = '0;
      rresp_o      = RESP_OKAY;
      rid_o        = '0;
      rlast_o      = 1'b0;
      beat_idx     = off_q + cnt_q[2:0];
      is_last      = (cnt_q == len_q);

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               off_d    = head_addr[2:0];
               id_d     = head_id;
               len_d    = head_len;
               err_d    = !head_legal;
               cnt_d    = '0;
               if (head_legal) begin
                  line_rden_o = 1'b1;
                  state_d     = LOAD;
               end else begin
                  state_d     = SEND;
               end
            end
         end
         LOAD: begin
            line_d  = line_rdata_i;
            cnt_d   = '0;
            state_d = SEND;
         end
         SEND: begin
            // All beat outputs derive from flops, so they hold while the receiver stalls.
            rvalid_o = 1'b1;
            rid_o    = id_q;
            rlast_o  = is_last;
            if (err_q) begin
               rresp_o = RESP_SLVERR;
            end else begin
               rdata_o = line_words[beat_idx];
            end
            if (rready_i) begin
               cnt_d = cnt_q + 4'd1;
               if (is_last) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         off_q   <= '0;
         id_q    <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         id_q    <= id_d;
         len_q   <= len_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      line_q <= line_d;
   end

endmodule

// File: tb/tb_mem_rd_burst_responder.sv
// Self-checking bench for mem_rd_burst_responder: request table plus hand-written
// latency, stall, queue-full and mid-burst reset sequences, checked by a beat scoreboard.
module tb_mem_rd_burst_responder;
   import mem_axi_pkg::*;

   localparam int ID_W = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              arvalid_i = 1'b0;
   logic              arready_o;
   logic [31:0]       araddr_i = '0;
   logic [ID_W-1:0]   arid_i = '0;
   logic [3:0]        arlen_i = '0;
   logic [2:0]        arsize_i = '0;
   logic [1:0]        arburst_i = '0;
   logic              rvalid_o;
   logic              rready_i = 1'b0;
   logic [63:0]       rdata_o;
   logic [1:0]        rresp_o;
   logic [ID_W-1:0]   rid_o;
   logic              rlast_o;
   logic              line_rden_o;
   logic [25:0]       line_raddr_o;
   logic [LINE_W-1:0] line_rdata_i = '0;

   always #5 clk = ~clk;

   mem_rd_burst_responder #(.AR_FIFO_DEPTH(4), .ID_W(ID_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .arvalid_i    (arvalid_i),
      .arready_o    (arready_o),
      .araddr_i     (araddr_i),
      .arid_i       (arid_i),
      .arlen_i      (arlen_i),
      .arsize_i     (arsize_i),
      .arburst_i    (arburst_i),
      .rvalid_o     (rvalid_o),
      .rready_i     (rready_i),
      .rdata_o      (rdata_o),
      .rresp_o      (rresp_o),
      .rid_o        (rid_o),
      .rlast_o      (rlast_o),
      .line_rden_o  (line_rden_o),
      .line_raddr_o (line_raddr_o),
      .line_rdata_i (line_rdata_i)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  id;
      logic [3:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          exp_rden;
      int          exp_beats;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic [1:0]  resp;
      logic [3:0]  id;
      logic        last;
   } beat_t;

   beat_t sb[$];
   vec_t  vecs[9];
   int    n_vec = 0;
   int    n_bad = 0;
   int    beats_seen = 0;
   int    rden_count = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] word_of(input logic [25:0] li, input int k);
      return {32'h1111_1111, li[23:0], 8'(k)};
   endfunction

   // Storage model: data becomes valid the cycle after the enable and is garbage otherwise.
   logic prev_rden = 1'b0;
   always @(negedge clk) begin
      if (line_rden_o) begin
         rden_count++;
         for (int k = 0; k < 8; k++) line_rdata_i[64*k +: 64] = word_of(line_raddr_o, k);
      end else if (!prev_rden) begin
         line_rdata_i = {8{64'hDEAD_BEEF_CAFE_F00D}};
      end
      prev_rden = line_rden_o;
   end

   // Beat monitor: scoreboard compare, stall stability, bubble after each burst.
   logic        stall_prev = 1'b0;
   logic        gap_exp = 1'b0;
   logic [70:0] prev_beat = '0;
   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) begin
         stall_prev = 1'b0;
         gap_exp = 1'b0;
      end else begin
         if (gap_exp) check("bubble_after_last", rvalid_o, 1'b0);
         gap_exp = 1'b0;
         if (stall_prev)
            check("stall_hold", {rvalid_o, rdata_o, rresp_o, rid_o, rlast_o}, {1'b1, prev_beat});
         if (rvalid_o && rready_i) begin
            if (sb.size() == 0) begin
               check("unexpected_beat", rvalid_o, 1'b0);
            end else begin
               e = sb.pop_front();
               check("beat", {rdata_o, rresp_o, rid_o, rlast_o}, {e.data, e.resp, e.id, e.last});
               $display("beat id=%0h data=%016h resp=%0d last=%0b", rid_o, rdata_o, rresp_o, rlast_o);
               beats_seen++;
               if (rlast_o) gap_exp = 1'b1;
            end
         end
         stall_prev = rvalid_o && !rready_i;
         prev_beat  = {rdata_o, rresp_o, rid_o, rlast_o};
      end
   end

   task automatic push_expected(input vec_t v);
      beat_t b;
      int off = int'(v.addr[5:3]);
      for (int i = 0; i < v.exp_beats; i++) begin
         b.data = (v.exp_rden != 0) ? word_of(v.addr[31:6], (off + i) % 8) : 64'h0;
         b.resp = (v.exp_rden != 0) ? 2'b00 : 2'b10;
         b.id   = v.id;
         b.last = (i == v.exp_beats - 1);
         sb.push_back(b);
      end
   endtask

   // Returns at posedge+1 of the cycle right after the AR handshake.
   task automatic send_ar(input vec_t v);
      int n = 0;
      @(posedge clk); #1;
      while (!arready_o && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      check("arready_wait", arready_o, 1'b1);
      arvalid_i = 1'b1;
      araddr_i  = v.addr;
      arid_i    = v.id;
      arlen_i   = v.len;
      arsize_i  = v.size;
      arburst_i = v.burst;
      push_expected(v);
      $display("ar addr=%08h id=%0h len=%0d size=%0d burst=%0d", v.addr, v.id, v.len, v.size, v.burst);
      @(posedge clk); #1;
      arvalid_i = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || rvalid_o) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_left", sb.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      int   r0, b0, n;
      logic d1, d2;

      vecs[0] = '{32'h0000_1218, 4'h1, 4'd7,  3'd3, BURST_WRAP,  1, 8};
      vecs[1] = '{32'h0000_2000, 4'h2, 4'd7,  3'd3, BURST_WRAP,  1, 8};
      vecs[2] = '{32'h0000_3038, 4'h3, 4'd7,  3'd3, BURST_WRAP,  1, 8};
      vecs[3] = '{32'h0000_4010, 4'h4, 4'd3,  3'd3, BURST_INCR,  0, 4};
      vecs[4] = '{32'h0000_5008, 4'h5, 4'd7,  3'd2, BURST_WRAP,  0, 8};
      vecs[5] = '{32'h0000_6000, 4'h6, 4'd7,  3'd3, BURST_FIXED, 0, 8};
      vecs[6] = '{32'h0000_7028, 4'h7, 4'd15, 3'd3, BURST_WRAP,  0, 16};
      vecs[7] = '{32'h0000_8000, 4'h8, 4'd0,  3'd3, BURST_WRAP,  0, 1};
      vecs[8] = '{32'hFFFF_FFC8, 4'h9, 4'd7,  3'd3, BURST_WRAP,  1, 8};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {rvalid_o, rlast_o, rdata_o, rresp_o, rid_o, line_rden_o}, '0);
      check("reset_arready", arready_o, 1'b1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("arready_after_reset", arready_o, 1'b1);

      // Latency of the first burst: rden at T+1, first beat at T+3.
      rready_i = 1'b1;
      send_ar(vecs[0]);
      check("lat_rden_t1", line_rden_o, 1'b1);
      check("lat_raddr", line_raddr_o, 26'h48);
      check("lat_rvalid_t1", rvalid_o, 1'b0);
      @(posedge clk); #1;
      check("lat_rvalid_t2", {rvalid_o, line_rden_o}, 2'b00);
      @(posedge clk); #1;
      check("lat_rvalid_t3", rvalid_o, 1'b1);
      wait_drain();

      // Request table.
      for (int i = 0; i < 9; i++) begin
         r0 = rden_count;
         b0 = beats_seen;
         send_ar(vecs[i]);
         wait_drain();
         check("rden_pulses", rden_count - r0, vecs[i].exp_rden);
         check("beat_count", beats_seen - b0, vecs[i].exp_beats);
      end

      // Stalls of 3 cycles on beats 2 and 5.
      v = vecs[0];
      v.id = 4'hA;
      b0 = beats_seen;
      d1 = 1'b0;
      d2 = 1'b0;
      send_ar(v);
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         if (beats_seen - b0 == 1 && !d1) begin
            rready_i = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rready_i = 1'b1;
            d1 = 1'b1;
         end else if (beats_seen - b0 == 4 && !d2) begin
            rready_i = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rready_i = 1'b1;
            d2 = 1'b1;
         end
         @(posedge clk); #1;
         n++;
      end
      wait_drain();
      check("stall_beats", beats_seen - b0, 8);

      // Queue fill with the R channel blocked: one active burst plus four queued.
      rready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         v = vecs[i % 3];
         v.id = 4'(i);
         send_ar(v);
      end
      check("arready_full", arready_o, 1'b0);
      arvalid_i = 1'b1;
      araddr_i  = 32'h0000_9000;
      arid_i    = 4'hF;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("arready_held_low", arready_o, 1'b0);
      end
      arvalid_i = 1'b0;
      rready_i  = 1'b1;
      wait_drain();

      // Reset during beat 4 with two requests still queued.
      rready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         v = vecs[1];
         v.id = 4'(i + 4);
         send_ar(v);
      end
      n = 0;
      while (!rvalid_o && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      b0 = beats_seen;
      rready_i = 1'b1;
      n = 0;
      while (beats_seen - b0 < 3 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("pre_reset_beats", beats_seen - b0, 3);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_reset_rvalid", {rvalid_o, rlast_o, rdata_o, rid_o, rresp_o}, '0);
      check("mid_reset_arready", arready_o, 1'b1);
      sb.delete();
      rst_n = 1'b1;
      b0 = beats_seen;
      r0 = rden_count;
      repeat (40) @(posedge clk);
      #1;
      check("post_reset_beats", beats_seen - b0, 0);
      check("post_reset_rden", rden_count - r0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
